// File: rtl/di_term_pkg.sv
// di_term_pkg: shared constants for the di_fifo_term register terminal.
//   Register addresses, STATUS/CONTROL bit positions, and a decoder that
//   maps a 16-bit register address onto a small register-select enum.
package di_term_pkg;

  localparam logic [15:0] REG_STATUS    = 16'h0000;
  localparam logic [15:0] REG_CONTROL   = 16'h0001;
  localparam logic [15:0] REG_H2D_COUNT = 16'h0002;
  localparam logic [15:0] REG_D2H_COUNT = 16'h0003;
  localparam logic [15:0] DATA_BASE     = 16'h0100;

  localparam int ST_H2D_OVF    = 15;
  localparam int ST_D2H_UNF    = 14;
  localparam int ST_D2H_EMPTY  = 1;
  localparam int ST_H2D_FULL   = 0;

  localparam int CTL_H2D_FLUSH = 0;
  localparam int CTL_D2H_FLUSH = 1;

  typedef enum logic [2:0] {
    SEL_STATUS,
    SEL_CONTROL,
    SEL_H2D_CNT,
    SEL_D2H_CNT,
    SEL_RSVD,
    SEL_DATA
  } reg_sel_e;

  // Everything from DATA_BASE up is the data window; 0x0004..0x00FF is reserved.
  function automatic reg_sel_e decode_reg(input logic [15:0] a);
    if (a >= DATA_BASE)          return SEL_DATA;
    else if (a == REG_STATUS)    return SEL_STATUS;
    else if (a == REG_CONTROL)   return SEL_CONTROL;
    else if (a == REG_H2D_COUNT) return SEL_H2D_CNT;
    else if (a == REG_D2H_COUNT) return SEL_D2H_CNT;
    else                         return SEL_RSVD;
  endfunction

endpackage

// File: rtl/di_sync_fifo.sv
// di_sync_fifo: 16-bit first-word-fall-through synchronous FIFO.
//   clk_i/rst_i    clock, synchronous active-high reset
//   push_i/wdata_i write one word (ignored when full)
//   pop_i          consume head word (ignored when empty)
//   flush_i        empty the FIFO; beats a same-cycle push/pop
//   rdata_o        head word, 0 while empty
//   count_o        occupancy 0..DEPTH; full_o / empty_o status
module di_sync_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [15:0]                wdata_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [15:0]                rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  import di_term_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  // Masking the head keeps stale RAM contents off the outputs after reset/flush.
  assign rdata_o = empty_o ? 16'h0000 : mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/di_fifo_term.sv
// di_fifo_term: di_* register-bus terminal with host-to-device and
// device-to-host FIFOs plus a small STATUS/CONTROL/COUNT register set.
//   ifclk/reset      clock, synchronous active-high reset
//   di_term_addr     terminal select, block answers to TERM_ADDR
//   di_reg_addr      register select; >= 0x0100 is the data window
//   di_reg_datai     write data; di_write / di_read one-cycle strobes
//   di_read_req      unused, the d2h head is always presented (FWFT)
//   di_reg_datao     read data, di_read_rdy / di_write_rdy handshakes
//   h2d_*            host-to-device stream out (valid/ready)
//   d2h_*            device-to-host stream in (valid/ready)
module di_fifo_term #(
  parameter logic [15:0] TERM_ADDR = 16'h0010,
  parameter int          DEPTH     = 16,
  parameter int          AW        = $clog2(DEPTH)
) (
  input  logic        ifclk,
  input  logic        reset,
  input  logic [15:0] di_term_addr,
  input  logic [15:0] di_reg_addr,
  input  logic [15:0] di_reg_datai,
  input  logic        di_write,
  input  logic        di_read,
  input  logic        di_read_req,
  output logic [15:0] di_reg_datao,
  output logic        di_read_rdy,
  output logic        di_write_rdy,
  output logic [15:0] h2d_data,
  output logic        h2d_valid,
  input  logic        h2d_ready,
  input  logic [15:0] d2h_data,
  input  logic        d2h_valid,
  output logic        d2h_ready
);
  import di_term_pkg::*;

  logic        sel;
  reg_sel_e    rsel;
  logic        wr_data, rd_data, wr_ctl;
  logic        h2d_flush, d2h_flush;
  logic        h2d_full, h2d_empty, d2h_full, d2h_empty;
  logic [AW:0] h2d_cnt, d2h_cnt;
  logic [15:0] d2h_head;
  logic        ovf_q, ovf_d, unf_q, unf_d;
  logic        ovf_set, unf_set;
  logic [15:0] status;
  logic        unused_ok;

  assign unused_ok = &{1'b0, di_read_req};

  assign sel       = (di_term_addr == TERM_ADDR);
  assign rsel      = decode_reg(di_reg_addr);
  assign wr_data   = sel & di_write & (rsel == SEL_DATA);
  assign rd_data   = sel & di_read  & (rsel == SEL_DATA);
  assign wr_ctl    = sel & di_write & (rsel == SEL_CONTROL);
  assign h2d_flush = wr_ctl & di_reg_datai[CTL_H2D_FLUSH];
  assign d2h_flush = wr_ctl & di_reg_datai[CTL_D2H_FLUSH];
  assign ovf_set   = wr_data & h2d_full;
  assign unf_set   = rd_data & d2h_empty;

  di_sync_fifo #(.DEPTH(DEPTH)) u_h2d (
    .clk_i   (ifclk),
    .rst_i   (reset),
    .push_i  (wr_data),
    .wdata_i (di_reg_datai),
    .pop_i   (h2d_valid & h2d_ready),
    .flush_i (h2d_flush),
    .rdata_o (h2d_data),
    .count_o (h2d_cnt),
    .full_o  (h2d_full),
    .empty_o (h2d_empty)
  );

  di_sync_fifo #(.DEPTH(DEPTH)) u_d2h (
    .clk_i   (ifclk),
    .rst_i   (reset),
    .push_i  (d2h_valid & d2h_ready),
    .wdata_i (d2h_data),
    .pop_i   (rd_data),
    .flush_i (d2h_flush),
    .rdata_o (d2h_head),
    .count_o (d2h_cnt),
    .full_o  (d2h_full),
    .empty_o (d2h_empty)
  );

  assign h2d_valid = ~h2d_empty;
  assign d2h_ready = ~d2h_full;

  // A new error in the same cycle as a CONTROL clear keeps the flag set.
  always_comb begin
    ovf_d = ovf_set ? 1'b1 : (h2d_flush ? 1'b0 : ovf_q);
    unf_d = unf_set ? 1'b1 : (d2h_flush ? 1'b0 : unf_q);
  end

  always_ff @(posedge ifclk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_comb begin
    status               = 16'h0000;
    status[ST_H2D_OVF]   = ovf_q;
    status[ST_D2H_UNF]   = unf_q;
    status[ST_D2H_EMPTY] = d2h_empty;
    status[ST_H2D_FULL]  = h2d_full;
  end

  // Combinational read path: the host registers di_reg_datao itself.
  always_comb begin
    di_reg_datao = 16'h0000;
    di_read_rdy  = 1'b0;
    di_write_rdy = 1'b0;
    if (sel) begin
      di_read_rdy  = 1'b1;
      di_write_rdy = 1'b1;
      case (rsel)
        SEL_STATUS:  di_reg_datao = status;
        SEL_H2D_CNT: di_reg_datao = 16'(h2d_cnt);
        SEL_D2H_CNT: di_reg_datao = 16'(d2h_cnt);
        SEL_DATA: begin
          di_reg_datao = d2h_head;
          di_read_rdy  = ~d2h_empty;
          di_write_rdy = ~h2d_full;
        end
        default:     di_reg_datao = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_di_fifo_term.sv
module tb_di_fifo_term;
  localparam logic [15:0] TERM = 16'h0010;

  logic        ifclk = 1'b0;
  logic        reset;
  logic [15:0] di_term_addr, di_reg_addr, di_reg_datai;
  logic        di_write, di_read, di_read_req;
  logic [15:0] di_reg_datao;
  logic        di_read_rdy, di_write_rdy;
  logic [15:0] h2d_data;
  logic        h2d_valid, h2d_ready;
  logic [15:0] d2h_data;
  logic        d2h_valid, d2h_ready;

  di_fifo_term #(.TERM_ADDR(TERM), .DEPTH(16)) dut (
    .ifclk(ifclk), .reset(reset),
    .di_term_addr(di_term_addr), .di_reg_addr(di_reg_addr), .di_reg_datai(di_reg_datai),
    .di_write(di_write), .di_read(di_read), .di_read_req(di_read_req),
    .di_reg_datao(di_reg_datao), .di_read_rdy(di_read_rdy), .di_write_rdy(di_write_rdy),
    .h2d_data(h2d_data), .h2d_valid(h2d_valid), .h2d_ready(h2d_ready),
    .d2h_data(d2h_data), .d2h_valid(d2h_valid), .d2h_ready(d2h_ready)
  );

  always #5 ifclk = ~ifclk;

  typedef struct { logic [15:0] val; string name; } exp_t;
  exp_t        reg_q[$];
  logic [15:0] d2h_q[$];
  logic [15:0] h2d_q[$];
  exp_t        mon_e;
  logic [15:0] mon_w;
  logic        probe_en;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  always @(negedge ifclk) begin
    if (probe_en) begin
      if (reg_q.size() == 0) chk("probe_queue_empty", 16'h0001, 16'h0000);
      else begin
        mon_e = reg_q.pop_front();
        chk(mon_e.name, di_reg_datao, mon_e.val);
      end
    end
    if (di_term_addr == TERM && di_read && di_reg_addr >= 16'h0100 && di_read_rdy) begin
      if (d2h_q.size() == 0) chk("d2h_unexpected_pop", di_reg_datao, 16'hxxxx);
      else begin
        mon_w = d2h_q.pop_front();
        chk("d2h_burst_data", di_reg_datao, mon_w);
      end
    end
    if (h2d_valid && h2d_ready) begin
      if (h2d_q.size() == 0) chk("h2d_unexpected_pop", h2d_data, 16'hxxxx);
      else begin
        mon_w = h2d_q.pop_front();
        chk("h2d_stream_data", h2d_data, mon_w);
      end
    end
  end

  task automatic cyc();
    @(posedge ifclk);
    #1;
  endtask

  task automatic probe(input logic [15:0] addr, input logic [15:0] exp, input string name);
    exp_t e;
    e.val = exp;
    e.name = name;
    di_reg_addr = addr;
    reg_q.push_back(e);
    probe_en = 1'b1;
    cyc();
    probe_en = 1'b0;
  endtask

  task automatic host_wr(input logic [15:0] addr, input logic [15:0] data);
    di_reg_addr  = addr;
    di_reg_datai = data;
    di_write     = 1'b1;
    cyc();
    di_write     = 1'b0;
  endtask

  task automatic d2h_push(input logic [15:0] base, input int n);
    d2h_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      d2h_data = base + 16'(i);
      cyc();
    end
    d2h_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; di_term_addr = 16'h0000; di_reg_addr = 16'h0000; di_reg_datai = 16'h0000;
    di_write = 1'b0; di_read = 1'b0; di_read_req = 1'b0; h2d_ready = 1'b0;
    d2h_data = 16'h0000; d2h_valid = 1'b0; probe_en = 1'b0;
    cyc(); cyc();
    reset = 1'b0;

    // Reset state, unselected then selected at STATUS
    #1;
    chk("unsel_datao", di_reg_datao, 16'h0000);
    chk("unsel_rrdy", {15'b0, di_read_rdy}, 16'h0000);
    chk("unsel_wrdy", {15'b0, di_write_rdy}, 16'h0000);
    chk("rst_h2d_valid", {15'b0, h2d_valid}, 16'h0000);
    chk("rst_h2d_data", h2d_data, 16'h0000);
    chk("rst_d2h_ready", {15'b0, d2h_ready}, 16'h0001);
    di_term_addr = TERM;
    probe(16'h0000, 16'h0002, "rst_status");

    // d2h burst read A000..A003
    d2h_push(16'hA000, 4);
    for (int i = 0; i < 4; i++) d2h_q.push_back(16'hA000 + 16'(i));
    probe(16'h0003, 16'h0004, "d2h_count_4");
    di_reg_addr = 16'h0100;
    di_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      di_reg_addr = di_reg_addr + 16'h0001;
    end
    di_read = 1'b0;
    #1;
    chk("rrdy_after_burst", {15'b0, di_read_rdy}, 16'h0000);
    chk("d2h_burst_consumed", 16'(d2h_q.size()), 16'h0000);
    probe(16'h0003, 16'h0000, "d2h_count_0");

    // h2d overflow: 17 writes into a 16-deep FIFO, then flush
    di_reg_addr = 16'h0100;
    di_write = 1'b1;
    for (int i = 0; i < 17; i++) begin
      di_reg_datai = 16'hB000 + 16'(i);
      #1;
      if (i == 0)  chk("wrdy_first", {15'b0, di_write_rdy}, 16'h0001);
      if (i == 16) chk("wrdy_before_17th", {15'b0, di_write_rdy}, 16'h0000);
      cyc();
    end
    di_write = 1'b0;
    probe(16'h0002, 16'h0010, "h2d_count_full");
    probe(16'h0000, 16'h8003, "status_ovf_full");
    host_wr(16'h0001, 16'h0001);
    probe(16'h0002, 16'h0000, "h2d_count_flushed");
    probe(16'h0000, 16'h0002, "status_ovf_cleared");
    probe(16'h0001, 16'h0000, "control_reads_0");
    probe(16'h0004, 16'h0000, "reserved_reads_0");
    #1;
    chk("reserved_rrdy", {15'b0, di_read_rdy}, 16'h0001);

    // Simultaneous host push and user pop at count 5
    for (int i = 0; i < 5; i++) begin
      h2d_q.push_back(16'hC000 + 16'(i));
      host_wr(16'h0100, 16'hC000 + 16'(i));
    end
    probe(16'h0002, 16'h0005, "h2d_count_5");
    h2d_q.push_back(16'hC005);
    di_reg_addr = 16'h0100; di_reg_datai = 16'hC005; di_write = 1'b1; h2d_ready = 1'b1;
    cyc();
    di_write = 1'b0; h2d_ready = 1'b0;
    probe(16'h0002, 16'h0005, "h2d_count_still_5");
    h2d_ready = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    h2d_ready = 1'b0;
    #1;
    chk("h2d_drained_valid", {15'b0, h2d_valid}, 16'h0000);
    chk("h2d_stream_consumed", 16'(h2d_q.size()), 16'h0000);

    // Read of empty d2h data window: underflow
    di_read = 1'b1;
    probe(16'h0100, 16'h0000, "empty_data_read");
    di_read = 1'b0;
    probe(16'h0000, 16'h4002, "status_underflow");
    probe(16'h0003, 16'h0000, "d2h_count_after_unf");
    host_wr(16'h0001, 16'h0002);
    probe(16'h0000, 16'h0002, "status_unf_cleared");

    // Mid-burst reset with flags set and data in both FIFOs
    di_reg_addr = 16'h0100;
    di_write = 1'b1;
    for (int i = 0; i < 17; i++) begin
      di_reg_datai = 16'hD000 + 16'(i);
      cyc();
    end
    di_write = 1'b0;
    d2h_push(16'hE000, 4);
    di_read = 1'b1;
    probe(16'h0000, 16'h8001, "wrap_status_no_pop");
    di_read = 1'b0;
    probe(16'h0003, 16'h0004, "d2h_count_no_pop");
    d2h_q.push_back(16'hE000);
    d2h_q.push_back(16'hE001);
    di_reg_addr = 16'h0100;
    di_read = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      di_reg_addr = di_reg_addr + 16'h0001;
    end
    di_read = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    chk("mrst_h2d_valid", {15'b0, h2d_valid}, 16'h0000);
    chk("mrst_d2h_ready", {15'b0, d2h_ready}, 16'h0001);
    chk("mrst_burst_consumed", 16'(d2h_q.size()), 16'h0000);
    probe(16'h0000, 16'h0002, "mrst_status");
    probe(16'h0002, 16'h0000, "mrst_h2d_count");
    probe(16'h0003, 16'h0000, "mrst_d2h_count");

    cyc();
    chk("probes_consumed", 16'(reg_q.size()), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/di_fifo_term.md
Name: di_fifo_term

Overview:
- Device-side terminal sitting directly downstream of the host interface block on the di_* register bus.
- When di_term_addr matches TERM_ADDR, it accepts host data-port writes into a host-to-device FIFO, drained by user logic through a valid/ready stream.
- It supplies host data-port reads from a device-to-host FIFO, filled by user logic, with first-word-fall-through so burst reads (RDDATA) run at one word per cycle.
- Small status/control register set for FIFO levels, sticky error flags and flush.

Parameters:
- TERM_ADDR, 16'h0010, terminal address this block answers to.
- DEPTH, 16, entries per FIFO; power of two, 2..1024.
- AW, $clog2(DEPTH), FIFO pointer width (derived, do not override).

Ports:
- ifclk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- di_term_addr  in  16  terminal select.
- di_reg_addr  in  16  register select within terminal.
- di_reg_datai  in  16  write data.
- di_write  in  1  one-cycle write strobe.
- di_read  in  1  one-cycle read/consume strobe.
- di_read_req  in  1  pre-read request; ignored (FWFT makes it unnecessary).
- di_reg_datao  out  16  read data for the currently addressed register.
- di_read_rdy  out  1  read may proceed.
- di_write_rdy  out  1  write may proceed.
- h2d_data  out  16  host-to-device stream data.
- h2d_valid  out  1  h2d FIFO not empty.
- h2d_ready  in  1  user consumes when high with h2d_valid.
- d2h_data  in  16  device-to-host stream data.
- d2h_valid  in  1  user offers a word.
- d2h_ready  out  1  d2h FIFO not full.

Behaviour:
- sel = (di_term_addr == TERM_ADDR). When sel is low, di_read_rdy = 0, di_write_rdy = 0, di_reg_datao = 0, and strobes are ignored.
- Register map:
  - 0x0000 STATUS (RO): [15] h2d_overflow sticky, [14] d2h_underflow sticky, [1] d2h_empty, [0] h2d_full.
  - 0x0001 CONTROL (WO): bit0 flushes h2d FIFO and clears overflow; bit1 flushes d2h FIFO and clears underflow. Reads of 0x0001 return 0.
  - 0x0002 H2D_COUNT (RO), zero-extended, range 0..DEPTH.
  - 0x0003 D2H_COUNT (RO), zero-extended, range 0..DEPTH.
  - 0x0004..0x00FF reserved: read 0, writes ignored, rdy = 1.
  - 0x0100..0xFFFF DATA window. The host increments reg_addr on each burst read, so bursts must start inside the window. Wrap from 0xFFFF lands on STATUS: a read there returns STATUS and does not pop.
- di_reg_datao, di_read_rdy and di_write_rdy are combinational from registered state and addresses. There are no extra pipeline stages, because the host registers datao itself.
- DATA read:
  - di_reg_datao = d2h head word; di_read_rdy = !d2h_empty.
  - di_read pops exactly one word; the next head appears on the next cycle.
  - di_read while empty: no pop, underflow set, data reads 0.
- DATA write:
  - di_write_rdy = !h2d_full.
  - di_write pushes di_reg_datai.
  - di_write while full: word dropped, overflow set.
- Non-DATA registers: di_read_rdy = di_write_rdy = 1.
- FIFOs: registered count, simultaneous push and pop on the same FIFO leaves the count unchanged; pointers wrap modulo DEPTH.
  - h2d is pushed by the host and popped by h2d_valid & h2d_ready.
  - d2h is pushed by d2h_valid & d2h_ready and popped by the host.
- A flush in the same cycle as a push or pop wins: the count becomes 0 and the pushed word is discarded.
- Sticky flags: set wins over nothing; a clear via CONTROL in the same cycle as a new error leaves the flag set.
- Reset (synchronous, mid-operation allowed): both FIFOs empty, flags 0. Outputs after reset: h2d_valid = 0, d2h_ready = 1, h2d_data = 0, di_reg_datao = 0 (unselected) or STATUS = 0x0002 if selected at reg 0 (d2h_empty set).

Decomposition:
- Shared package di_term_pkg: register address constants (REG_STATUS, REG_CONTROL, REG_H2D_COUNT, REG_D2H_COUNT, DATA_BASE = 16'h0100) and STATUS/CONTROL bit indices.
- One sub-module, di_sync_fifo: DEPTH-parameterised, 16-bit FWFT, with push, pop, flush, count, full and empty. Instantiated twice.

Test Plan:
- Reset, then select TERM_ADDR with reg 0 -> di_reg_datao = 0x0002, d2h_ready = 1, h2d_valid = 0.
- User pushes 0xA000..0xA003 to d2h; host burst reads 4 with reg_addr starting 0x0100, one di_read per cycle -> datao sequence A000, A001, A002, A003; D2H_COUNT goes 4 then 0; di_read_rdy drops after the 4th pop.
- Host writes 17 words at DEPTH = 16 with h2d_ready = 0 -> first 16 stored, di_write_rdy = 0 before the 17th, STATUS[15] = 1; write 0x0001 to CONTROL -> H2D_COUNT = 0, STATUS[15] = 0.
- Host write to h2d and user pop in the same cycle with count 5 -> count stays 5, order preserved.
- di_read on empty d2h -> datao 0, STATUS = 0xC002 is not expected; STATUS = 0x4002 (underflow plus empty), count remains 0.
- Assert reset mid-burst after 2 of 4 pops -> next cycle both counts 0, flags 0, h2d_valid = 0.
